// File: rtl/dmem_bytelane.sv
// dmem_bytelane: RV32I data memory with byte lanes, req/ready handshake, registered loads and post-reset clear
module dmem_bytelane #(
  parameter int ADDR_W   = 12,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Req,
  input  logic              MemWr,
  input  logic [2:0]        MemOp,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       DataIn,
  output logic              Ready,
  output logic              RdValid,
  output logic [31:0]       DataOut,
  output logic              Err
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t           state, nextState;
  logic [IDX_W-1:0] cnt;
  logic [31:0]      mem [DEPTH];
  logic             accept, legal, misaligned, bad;
  logic [IDX_W-1:0] idx;
  logic [3:0]       byteEn;
  logic [31:0]      wrData, rdWord, loadData;
  logic [15:0]      shifted;

  assign idx    = Addr[ADDR_W-1:2];
  assign accept = Req && Ready;
  assign rdWord = mem[idx];

  // Leave the clear once the last word has been zeroed
  always_comb begin
    nextState = (state == CLEAR && cnt == IDX_W'(DEPTH - 1)) ? IDLE : state;
  end

  // State, clear counter and the registered Ready flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR_EN ? CLEAR : IDLE;
      cnt   <= '0;
      Ready <= 1'b0;
    end else begin
      state <= nextState;
      cnt   <= (state == CLEAR) ? cnt + 1'b1 : cnt;
      Ready <= (nextState == IDLE);
    end
  end

  // Decode legality, alignment, lane enables and replicated store data
  always_comb begin
    legal      = MemOp inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misaligned = (MemOp[1:0] == 2'b01 && Addr[0]) || (MemOp == 3'b010 && Addr[1:0] != 2'b00);
    bad        = !legal || misaligned;
    byteEn     = MemOp[1] ? 4'b1111 : MemOp[0] ? (Addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << Addr[1:0];
    wrData     = MemOp[1] ? DataIn : MemOp[0] ? {2{DataIn[15:0]}} : {4{DataIn[7:0]}};
  end

  // Lane shift then sign/zero extension; MemOp[2] selects unsigned
  always_comb begin
    shifted  = 16'(rdWord >> {Addr[1:0], 3'b000});
    loadData = MemOp[1] ? rdWord
             : MemOp[0] ? {{16{shifted[15] & ~MemOp[2]}}, shifted[15:0]}
             : {{24{shifted[7] & ~MemOp[2]}}, shifted[7:0]};
  end

  // Memory array: clear writes during CLEAR, masked byte writes for legal stores
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[cnt] <= '0;
    else if (accept && MemWr && !bad)
      for (int b = 0; b < 4; b++)
        if (byteEn[b]) mem[idx][8*b +: 8] <= wrData[8*b +: 8];
  end

  // Registered load result, valid strobe and error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RdValid <= 1'b0;
      Err     <= 1'b0;
      DataOut <= '0;
    end else begin
      RdValid <= accept && !MemWr;
      Err     <= accept && bad;
      DataOut <= (accept && !MemWr) ? (bad ? 32'h0 : loadData) : DataOut;
    end
  end
endmodule

// File: tb/tb_dmem_bytelane.sv
// tb_dmem_bytelane: scoreboard bench for dmem_bytelane with directed vectors
module tb_dmem_bytelane;
  logic        clk = 1'b0;
  logic        rst;
  logic        Req, MemWr;
  logic [2:0]  MemOp;
  logic [11:0] Addr;
  logic [31:0] DataIn;
  logic        Ready, RdValid, Err;
  logic [31:0] DataOut;

  typedef struct {
    string       name;
    logic        v;
    logic        e;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   n;

  dmem_bytelane dut (
    .clk(clk), .rst(rst), .Req(Req), .MemWr(MemWr), .MemOp(MemOp), .Addr(Addr),
    .DataIn(DataIn), .Ready(Ready), .RdValid(RdValid), .DataOut(DataOut), .Err(Err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic acc(input string name, input logic wr, input logic [2:0] op, input logic [11:0] a,
                     input logic [31:0] d, input logic ev, input logic ee, input logic [31:0] ed);
    exp_t x;
    @(negedge clk);
    Req = 1'b1; MemWr = wr; MemOp = op; Addr = a; DataIn = d;
    if (ev || ee) begin
      x.name = name; x.v = ev; x.e = ee; x.d = ed;
      q.push_back(x);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    Req = 1'b0;
  endtask

  task automatic waitReady(output int cnt);
    cnt = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk);
      #1;
      if (Ready) begin
        cnt = i;
        break;
      end
    end
  endtask

  // Monitor: every RdValid/Err pulse must match the oldest expected response
  always @(negedge clk) begin
    exp_t x;
    if (RdValid || Err) begin
      checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected: RdValid=%b Err=%b DataOut=%h, expected no response", RdValid, Err, DataOut);
      end else begin
        x = q.pop_front();
        if (RdValid === x.v && Err === x.e && (!x.v || DataOut === x.d)) passes++;
        else $display("FAIL %s: RdValid=%b Err=%b DataOut=%h, expected RdValid=%b Err=%b DataOut=%h",
                      x.name, RdValid, Err, DataOut, x.v, x.e, x.d);
      end
    end
  end

  initial begin
    exp_t x;
    rst = 1'b0; Req = 1'b1; MemWr = 1'b0; MemOp = 3'b010; Addr = 12'h3FC; DataIn = '0;
    x.name = "clear_lw_3fc"; x.v = 1'b1; x.e = 1'b0; x.d = 32'h0;
    q.push_back(x);
    #12;
    chk("rst_ready", {31'b0, Ready}, 32'd0);
    chk("rst_rdvalid", {31'b0, RdValid}, 32'd0);
    chk("rst_err", {31'b0, Err}, 32'd0);
    chk("rst_dataout", DataOut, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    waitReady(n);
    chk("clear_len", n, 32'd1024);
    @(posedge clk);
    #1;
    Req = 1'b0;
    acc("sw_0", 1, 3'b010, 12'h000, 32'hDEADBEEF, 0, 0, 0);
    acc("sw_4", 1, 3'b010, 12'h004, 32'h12345678, 0, 0, 0);
    acc("lw_0", 0, 3'b010, 12'h000, 0, 1, 0, 32'hDEADBEEF);
    acc("lw_4", 0, 3'b010, 12'h004, 0, 1, 0, 32'h12345678);
    acc("lb_3", 0, 3'b000, 12'h003, 0, 1, 0, 32'hFFFFFFDE);
    acc("lbu_1", 0, 3'b100, 12'h001, 0, 1, 0, 32'h000000BE);
    acc("lh_2", 0, 3'b001, 12'h002, 0, 1, 0, 32'hFFFFDEAD);
    acc("lhu_0", 0, 3'b101, 12'h000, 0, 1, 0, 32'h0000BEEF);
    acc("lb_4_pos", 0, 3'b000, 12'h004, 0, 1, 0, 32'h00000078);
    acc("sb_1", 1, 3'b000, 12'h001, 32'h0000AA12, 0, 0, 0);
    acc("sh_2", 1, 3'b001, 12'h002, 32'h00005566, 0, 0, 0);
    acc("lw_partial", 0, 3'b010, 12'h000, 0, 1, 0, 32'h556612EF);
    acc("sh_mis", 1, 3'b001, 12'h001, 32'h0000FFFF, 0, 1, 0);
    acc("lw_after_mis", 0, 3'b010, 12'h000, 0, 1, 0, 32'h556612EF);
    acc("lw_mis", 0, 3'b010, 12'h002, 0, 1, 1, 32'h0);
    acc("ld_011", 0, 3'b011, 12'h004, 0, 1, 1, 32'h0);
    acc("st_011", 1, 3'b011, 12'h004, 32'hCAFEF00D, 0, 1, 0);
    acc("lw_after_ill", 0, 3'b010, 12'h004, 0, 1, 0, 32'h12345678);
    idle();
    repeat (3) @(negedge clk);
    chk("drained_1", q.size(), 32'd0);
    @(negedge clk);
    Req = 1'b1; MemWr = 1'b0; MemOp = 3'b010; Addr = 12'h000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    Req = 1'b0;
    #1;
    chk("midrst_rdvalid", {31'b0, RdValid}, 32'd0);
    chk("midrst_dataout", DataOut, 32'h0);
    chk("midrst_ready", {31'b0, Ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    waitReady(n);
    chk("reclear_len", n, 32'd1024);
    acc("lw_after_clear", 0, 3'b010, 12'h000, 0, 1, 0, 32'h0);
    acc("lw4_after_clear", 0, 3'b010, 12'h004, 0, 1, 0, 32'h0);
    idle();
    repeat (4) @(negedge clk);
    chk("drained_2", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised single-port data memory for the RV32I core, the successor to `data_mem`. It supports the RV32I load/store widths: byte, halfword and word, with signed or unsigned loads. The block adds a req/ready handshake, a registered read path with a valid strobe, and misalignment and illegal-op detection. After every reset it runs a hardware clear sequence, so software always sees a zeroed memory. It sits between the core's MEM stage and the load-writeback mux.

## Interface
- `ADDR_W`, 12: byte-address width. Depth is `2**(ADDR_W-2)` 32-bit words.
- `CLEAR_EN`, 1: 1 zeroes every word after reset; 0 skips the clear, and Ready rises 1 cycle after reset release.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `Req` in 1: access request, sampled when `Ready`=1.
- `MemWr` in 1: 1 = store, 0 = load.
- `MemOp` in 3: funct3 encoding. 000 B, 001 H, 010 W, 100 BU, 101 HU. Codes 011/110/111 are illegal.
- `Addr` in ADDR_W: byte address.
- `DataIn` in 32: store data, right-aligned. Bits [7:0] are used for B, [15:0] for H.
- `Ready` out 1: block accepts a request this cycle.
- `RdValid` out 1: one-cycle pulse; `DataOut` holds load result.
- `DataOut` out 32: extended load data. Holds its value until the next RdValid.
- `Err` out 1: one-cycle pulse, 1 cycle after accepting a misaligned or illegal access.

## Operation
- FSM states:
  - CLEAR: `Ready`=0. Writes 0 to word `cnt`, `cnt`++ each cycle. On `cnt`=DEPTH-1, go to IDLE.
  - IDLE: `Ready`=1.
  - Reset forces CLEAR (or IDLE when `CLEAR_EN`=0) and sets `cnt`=0.
- Accept condition: `Req && Ready`. Only one access is in flight at a time. There is no back-pressure beyond `Ready`.
- Little-endian lanes: `Addr[1:0]` selects the byte lane; `Addr[1]` selects the halfword; word index = `Addr[ADDR_W-1:2]`.
- Stores:
  - Byte-enable mask writes only the addressed lanes.
  - Write commits at the accepting edge.
- Loads:
  - Word read, then lane shift, then extension. Sign-extend for B/H; zero-extend for BU/HU/W.
  - Result registered into `DataOut`.
- Misalignment:
  - H/HU with `Addr[0]`=1 is misaligned.
  - W with `Addr[1:0]`≠0 is misaligned.
- Misaligned or illegal access:
  - No memory write.
  - For a load, `DataOut` ← 0 and `RdValid`=1.
  - `Err`=1 on the same cycle, for loads and stores alike.
- Stores never raise `RdValid`.
- `Req` while `Ready`=0 is ignored, with no side effects.

## Timing
- Reset values:
  - `Ready`=0 (1 when `CLEAR_EN`=0 after first edge).
  - `RdValid`=0, `Err`=0, `DataOut`=0, `cnt`=0, state CLEAR.
  - Memory contents are undefined until the clear completes.
- Clear sequence: `Ready` rises on the DEPTH-th rising edge after reset deassertion. That is 1024 cycles for the default.
- Load latency: request accepted at edge N; `RdValid`/`DataOut` are valid after edge N+1 (1 cycle).
- Throughput: one access per cycle in IDLE. Back-to-back loads produce back-to-back `RdValid` pulses.
- Read after write: a store accepted at edge N followed by a load of the same word at edge N+1 returns the new data. No stale read is permitted.
- Reset asserted mid-clear or mid-load:
  - All outputs clear immediately (asynchronous).
  - A pending `RdValid` is dropped.
  - The clear restarts from word 0.
- Address wrap: none. `Addr` spans exactly the depth, and there are no out-of-range addresses.

## Test plan
- Reset/clear: release `rst`, hold `Req`=1 with LW @0x3FC. Required: `Ready`=0 for 1024 cycles, then the access is accepted, and `RdValid` next cycle with `DataOut`=0x00000000.
- Word round-trip: SW 0xDEADBEEF @0x000, SW 0x12345678 @0x004, LW @0x000, LW @0x004. Required: 0xDEADBEEF then 0x12345678 on consecutive `RdValid` cycles.
- Sub-word loads on 0xDEADBEEF @0x000:
  - LB @0x003 → 0xFFFFFFDE
  - LBU @0x001 → 0x000000BE
  - LH @0x002 → 0xFFFFDEAD
  - LHU @0x000 → 0x0000BEEF
- Partial stores: SB 0xAA12 @0x001 (only 0x12 used), then SH 0x5566 @0x002, then LW @0x000. Required: 0x556612EF, with the store immediately followed by the load.
- Errors:
  - SH @0x001 → `Err` pulse, memory unchanged (LW @0x000 still 0x556612EF).
  - LW @0x002 → `Err`+`RdValid`, `DataOut`=0.
  - MemOp=011 → `Err`.
- Reset mid-operation: accept LW, assert `rst` before the next edge. Required: no `RdValid`; after release, `Ready` is low for 1024 cycles and LW @0x000 returns 0.
